// File: rtl/conv_result_reader.sv
// conv_result_reader
//   Collects the conv_top result stream and tags each fp16 result with its
//   output-map (row,col) position. Tagged results are held in a FIFO that the
//   host drains through a request/response read port. conv_top cannot be
//   stalled, so a result that arrives while the FIFO is full is dropped and
//   a sticky overflow flag is raised.
// Ports
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   i_data/i_valid result stream from conv_top
//   i_clear        synchronous flush of FIFO, position counters and overflow
//   i_rd_data      host read request
//   o_rd_data/o_rd_row/o_rd_col/o_rd_valid  registered read response
//   o_count/o_empty/o_full                  FIFO occupancy
//   o_overflow     sticky drop flag
//   o_frame_done   one-cycle pulse after the last map position is taken
module conv_result_reader #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DEPTH  = 64,
  parameter int COL_W  = 3,
  parameter int ROW_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_valid,
  input  logic                     i_clear,
  input  logic                     i_rd_data,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [ROW_W-1:0]         o_rd_row,
  output logic [COL_W-1:0]         o_rd_col,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_frame_done
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = ROW_W + COL_W + DATA_W;

  logic [EW-1:0]     mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ROW_W-1:0]  rd_row_q, rd_row_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic              rd_valid_q, rd_valid_d;

  logic              rd_acc;
  logic              wr_acc;
  logic              mem_we;
  logic [EW-1:0]     rd_entry;

  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign rd_acc   = i_rd_data & ~empty_q & ~i_clear;
  assign wr_acc   = i_valid & (~full_q | (i_rd_data & ~empty_q)) & ~i_clear;
  assign mem_we   = wr_acc;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    frame_done_d = 1'b0;
    rd_data_d    = rd_data_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    rd_valid_d   = 1'b0;

    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      wr_row_d   = '0;
      wr_col_d   = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
        {rd_row_d, rd_col_d, rd_data_d} = rd_entry;
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
      if (i_valid && !wr_acc) begin
        overflow_d = 1'b1;
      end
      // Position advances on every strobe, dropped or not.
      if (i_valid) begin
        if (wr_col_q == COL_W'(OUT_W - 1)) begin
          wr_col_d = '0;
          if (wr_row_q == ROW_W'(OUT_H - 1)) begin
            wr_row_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            wr_row_d = wr_row_q + ROW_W'(1);
          end
        end else begin
          wr_col_d = wr_col_q + COL_W'(1);
        end
      end
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      frame_done_q <= 1'b0;
      rd_data_q    <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      frame_done_q <= frame_done_d;
      rd_data_q    <= rd_data_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {wr_row_q, wr_col_q, i_data};
    end
  end

  assign o_rd_data    = rd_data_q;
  assign o_rd_row     = rd_row_q;
  assign o_rd_col     = rd_col_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_count      = count_q;
  assign o_empty      = empty_q;
  assign o_full       = full_q;
  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader with a 5x5 image (3x3 map), DEPTH=8.
module tb_conv_result_reader;

  logic        clk;
  logic        rst;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_clear;
  logic        i_rd_data;
  logic [15:0] o_rd_data;
  logic [2:0]  o_rd_row;
  logic [2:0]  o_rd_col;
  logic        o_rd_valid;
  logic [3:0]  o_count;
  logic        o_empty;
  logic        o_full;
  logic        o_overflow;
  logic        o_frame_done;

  int unsigned n_vec;
  int unsigned n_mis;

  conv_result_reader #(
    .DATA_W(16),
    .IMG_W (5),
    .IMG_H (5),
    .DEPTH (8),
    .COL_W (3),
    .ROW_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_clear     (i_clear),
    .i_rd_data   (i_rd_data),
    .o_rd_data   (o_rd_data),
    .o_rd_row    (o_rd_row),
    .o_rd_col    (o_rd_col),
    .o_rd_valid  (o_rd_valid),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_frame_done(o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] d, input logic [2:0] r,
                        input logic [2:0] c);
    chk({tag, ".valid"}, 32'(o_rd_valid), 32'd1);
    chk({tag, ".data"},  32'(o_rd_data),  32'(d));
    chk({tag, ".row"},   32'(o_rd_row),   32'(r));
    chk({tag, ".col"},   32'(o_rd_col),   32'(c));
  endtask

  logic [15:0] exp_d [8];
  logic [2:0]  exp_r [8];
  logic [2:0]  exp_c [8];
  int unsigned fd_pulses;

  initial begin
    n_vec     = 0;
    n_mis     = 0;
    rst       = 1'b0;
    i_data    = '0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    i_rd_data = 1'b0;

    // 1: reset state
    #23;
    chk("rst.empty", 32'(o_empty), 32'd1);
    chk("rst.count", 32'(o_count), 32'd0);
    rst = 1'b1;
    step();
    chk("t1.empty",      32'(o_empty),      32'd1);
    chk("t1.count",      32'(o_count),      32'd0);
    chk("t1.full",       32'(o_full),       32'd0);
    chk("t1.rd_valid",   32'(o_rd_valid),   32'd0);
    chk("t1.overflow",   32'(o_overflow),   32'd0);
    chk("t1.frame_done", 32'(o_frame_done), 32'd0);
    chk("t1.rd_data",    32'(o_rd_data),    32'd0);

    // 2: three writes then three reads
    i_valid = 1'b1; i_data = 16'h3C00; step();
    i_data = 16'h4000; step();
    i_data = 16'h4200; step();
    i_valid = 1'b0;
    chk("t2.count", 32'(o_count), 32'd3);
    i_rd_data = 1'b1; step();
    chk_rd("t2.r0", 16'h3C00, 3'd0, 3'd0);
    step();
    chk_rd("t2.r1", 16'h4000, 3'd0, 3'd1);
    step();
    chk_rd("t2.r2", 16'h4200, 3'd0, 3'd2);
    chk("t2.empty", 32'(o_empty), 32'd1);
    i_rd_data = 1'b0; step();
    chk("t2.rd_valid_drop", 32'(o_rd_valid), 32'd0);
    chk("t2.rd_data_hold",  32'(o_rd_data),  32'h4200);

    // realign position counters to (0,0)
    i_clear = 1'b1; step();
    i_clear = 1'b0;
    chk("clr.empty", 32'(o_empty), 32'd1);

    // 3: nine writes into an 8-deep FIFO
    fd_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      i_valid = 1'b1;
      i_data  = 16'h1000 + 16'(i);
      step();
      if (o_frame_done) fd_pulses++;
      if (i < 8) begin
        exp_d[i] = 16'h1000 + 16'(i);
        exp_r[i] = 3'(i / 3);
        exp_c[i] = 3'(i % 3);
      end
      if (i == 6) chk("t3.full_at7", 32'(o_full), 32'd0);
      if (i == 7) begin
        chk("t3.full_at8",  32'(o_full),     32'd1);
        chk("t3.count_at8", 32'(o_count),    32'd8);
        chk("t3.ovf_at8",   32'(o_overflow), 32'd0);
      end
    end
    i_valid = 1'b0;
    chk("t3.overflow",   32'(o_overflow),   32'd1);
    chk("t3.count",      32'(o_count),      32'd8);
    chk("t3.frame_done", 32'(o_frame_done), 32'd1);
    step();
    if (o_frame_done) fd_pulses++;
    chk("t3.fd_pulses", 32'(fd_pulses), 32'd1);

    // 4: simultaneous write+read while full; new entry tagged (0,0)
    i_valid = 1'b1; i_data = 16'h5555; i_rd_data = 1'b1; step();
    i_valid = 1'b0;
    chk("t4.count",    32'(o_count),    32'd8);
    chk("t4.full",     32'(o_full),     32'd1);
    chk("t4.overflow", 32'(o_overflow), 32'd1);
    chk_rd("t4.r0", exp_d[0], exp_r[0], exp_c[0]);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_rd($sformatf("t4.r%0d", i), exp_d[i], exp_r[i], exp_c[i]);
    end
    step();
    chk_rd("t4.rnew", 16'h5555, 3'd0, 3'd0);
    chk("t4.empty", 32'(o_empty), 32'd1);

    // 5: read while empty, then clear with 4 entries held
    step();
    chk("t5.rd_empty_valid", 32'(o_rd_valid), 32'd0);
    chk("t5.rd_empty_count", 32'(o_count),    32'd0);
    i_rd_data = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'h2000 + 16'(i);
      step();
    end
    chk("t5.count4", 32'(o_count), 32'd4);
    // i_valid stays high during clear; that result must be discarded
    i_clear = 1'b1; i_rd_data = 1'b1; step();
    i_clear = 1'b0; i_valid = 1'b0; i_rd_data = 1'b0;
    chk("t5.clr_empty",    32'(o_empty),    32'd1);
    chk("t5.clr_count",    32'(o_count),    32'd0);
    chk("t5.clr_overflow", 32'(o_overflow), 32'd0);
    chk("t5.clr_rd_valid", 32'(o_rd_valid), 32'd0);

    // 6: async reset mid-frame
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_data = 16'h3000 + 16'(i);
      step();
    end
    i_valid = 1'b0;
    chk("t6.count5", 32'(o_count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.arst_count", 32'(o_count), 32'd0);
    chk("t6.arst_empty", 32'(o_empty), 32'd1);
    step();
    rst = 1'b1;
    i_valid = 1'b1; i_data = 16'h4400; step();
    i_valid = 1'b0; i_rd_data = 1'b1; step();
    i_rd_data = 1'b0;
    chk_rd("t6.r0", 16'h4400, 3'd0, 3'd0);
    chk("t6.empty", 32'(o_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
